regfile_seq: RTL and testbench
==============================

REGFILE_SEQ -- requirements
Module: regfile_seq

Interface
REQ-001 Parameter ADDR_W, default 5, SHALL set the register file address width (depth 2**ADDR_W = 32).
REQ-002 Parameter DATA_W, default 32, SHALL set the data width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 start  input  1  SHALL request one fill-then-drain sequence; sampled only in IDLE.
REQ-006 din  input  DATA_W  SHALL carry the write-stream data word.
REQ-007 din_valid  input  1 / din_ready  output  1  SHALL form the write-stream handshake.
REQ-008 address_w  output  ADDR_W / enable_w  output  1 / In  output  DATA_W  SHALL drive the register-file write port.
REQ-009 address_a, address_b  output  ADDR_W / enable_a, enable_b  output  1  SHALL drive register-file read ports A and B.
REQ-010 OutA, OutB  input  DATA_W  SHALL return register-file read data, valid one cycle after enable_a/enable_b are sampled high.
REQ-011 dout_a, dout_b  output  DATA_W / dout_valid  output  1 / dout_ready  input  1  SHALL form the read-stream handshake.
REQ-012 busy  output  1  SHALL be high in every state except IDLE; done  output  1  SHALL pulse for one cycle at sequence end.

Function
REQ-013 The FSM SHALL have states IDLE, WRITE, RD_ISSUE, RD_CAPT, RD_OUT, FIN.
REQ-014 IDLE: din_ready=0, all enables 0; start=1 SHALL move to WRITE with write counter wcnt=0 and pair counter pcnt=0.
REQ-015 WRITE: din_ready SHALL be 1; each cycle with din_valid&&din_ready SHALL register enable_w=1, address_w=wcnt, In=din for exactly the next cycle, then wcnt increments.
REQ-016 WRITE: a cycle without din_valid SHALL register enable_w=0; address_w and In hold their last values.
REQ-017 The handshake accepting wcnt=31 SHALL move the FSM to RD_ISSUE and de-assert din_ready the next cycle; no 33rd word is accepted; the final write (address 31) is driven while in RD_ISSUE and lands at the end of that cycle.
REQ-018 RD_ISSUE: SHALL drive enable_a=enable_b=1 for one cycle, address_a=pcnt, address_b=pcnt+16 (address_b = pcnt with MSB set); next state RD_CAPT.
REQ-019 RD_CAPT: enables SHALL be 0; OutA/OutB SHALL be captured into dout_a/dout_b; dout_valid SHALL rise next cycle; next state RD_OUT.
REQ-020 RD_OUT: dout_valid=1, dout_a/dout_b SHALL hold stable until dout_ready=1; on acceptance dout_valid drops next cycle, pcnt increments, next state RD_ISSUE, or FIN if pcnt was 15.
REQ-021 FIN: done=1 for one cycle, next state IDLE.
REQ-022 Minimum read throughput SHALL be one pair per 3 cycles with dout_ready held high.
REQ-023 Counters SHALL be ADDR_W bits (wcnt) and ADDR_W-1 bits (pcnt); no wrap beyond 31/15 occurs because the FSM exits first.
REQ-024 start while busy SHALL be ignored; din_valid outside WRITE SHALL be ignored; dout_ready outside RD_OUT SHALL be ignored.
REQ-025 enable_w SHALL never be high in the same cycle as enable_a or enable_b, except the final address-31 write, which is concurrent with the first RD_ISSUE and does not conflict (reads target addresses 0 and 16).

Reset
REQ-026 rst=1 at any clock edge SHALL force IDLE, wcnt=pcnt=0, and all of the following to 0: din_ready, enable_w, enable_a, enable_b, dout_valid, busy, done, address_w, address_a, address_b, In, dout_a, dout_b.
REQ-027 rst mid-sequence SHALL abort without any further register-file write or read strobe in the cycle after reset is sampled.

Verification
REQ-028 Fill/drain: start, 32 words din=i*0x01010101 with din_valid always high, dout_ready high, behavioural regfile model -> 32 enable_w pulses to addresses 0..31, then 16 outputs with dout_a=p*0x01010101, dout_b=(p+16)*0x01010101, done once.
REQ-029 Gapped input: din_valid toggled 1/0 -> enable_w high only the cycle after each accept; exactly 32 writes; address_w monotonic 0..31.
REQ-030 Backpressure: dout_ready held low 5 cycles at pair 3 -> dout_valid high and dout_a/dout_b unchanged for all 5 cycles, no enable_a/enable_b pulses meanwhile.
REQ-031 Reset mid-write at wcnt=10 -> next cycle all outputs 0, state IDLE; new start restarts at address_w=0.
REQ-032 start pulsed during RD_OUT and din_valid high during read phase -> no restart, din_ready stays 0, sequence completes with single done.

Source files
------------

// File: rtl/regfile_seq.sv
// regfile_seq: fills an external register file from a valid/ready write
// stream, then drains it as 16 address pairs (p, p+16) onto a valid/ready
// read stream. The register file itself lives outside this block; its
// read data returns one cycle after the read enables are sampled.
module regfile_seq #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [ADDR_W-1:0] address_w,
  output logic              enable_w,
  output logic [DATA_W-1:0] In,
  output logic [ADDR_W-1:0] address_a,
  output logic [ADDR_W-1:0] address_b,
  output logic              enable_a,
  output logic              enable_b,
  input  logic [DATA_W-1:0] OutA,
  input  logic [DATA_W-1:0] OutB,
  output logic [DATA_W-1:0] dout_a,
  output logic [DATA_W-1:0] dout_b,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] WCNT_LAST = '1;
  localparam logic [ADDR_W-2:0] PCNT_LAST = '1;
  localparam logic [ADDR_W-1:0] WCNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-2:0] PCNT_ONE  = {{(ADDR_W-2){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    RD_ISSUE = 3'd2,
    RD_CAPT  = 3'd3,
    RD_OUT   = 3'd4,
    FIN      = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [ADDR_W-2:0] pcnt_q, pcnt_d;
  logic [ADDR_W-2:0] pcnt_inc;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] raddr_a_q, raddr_a_d;
  logic [ADDR_W-1:0] raddr_b_q, raddr_b_d;
  logic [DATA_W-1:0] dout_a_q, dout_a_d;
  logic [DATA_W-1:0] dout_b_q, dout_b_d;

  assign pcnt_inc = pcnt_q + PCNT_ONE;

  // Next-state and next-register logic; write port and read addresses are
  // registered so every register-file strobe starts from a flop.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    pcnt_d    = pcnt_q;
    wen_d     = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    raddr_a_d = raddr_a_q;
    raddr_b_d = raddr_b_q;
    dout_a_d  = dout_a_q;
    dout_b_d  = dout_b_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WRITE;
          wcnt_d  = '0;
          pcnt_d  = '0;
        end
      end
      WRITE: begin
        if (din_valid) begin
          wen_d   = 1'b1;
          waddr_d = wcnt_q;
          wdata_d = din;
          wcnt_d  = wcnt_q + WCNT_ONE;
          if (wcnt_q == WCNT_LAST) begin
            // Last word: its write overlaps the first read issue, which
            // targets the low and high halves, never the last address.
            state_d   = RD_ISSUE;
            raddr_a_d = {1'b0, pcnt_q};
            raddr_b_d = {1'b1, pcnt_q};
          end
        end
      end
      RD_ISSUE: begin
        state_d = RD_CAPT;
      end
      RD_CAPT: begin
        dout_a_d = OutA;
        dout_b_d = OutB;
        state_d  = RD_OUT;
      end
      RD_OUT: begin
        if (dout_ready) begin
          if (pcnt_q == PCNT_LAST) begin
            state_d = FIN;
          end else begin
            pcnt_d    = pcnt_inc;
            raddr_a_d = {1'b0, pcnt_inc};
            raddr_b_d = {1'b1, pcnt_inc};
            state_d   = RD_ISSUE;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset to all-zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      pcnt_q    <= '0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      raddr_a_q <= '0;
      raddr_b_q <= '0;
      dout_a_q  <= '0;
      dout_b_q  <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      pcnt_q    <= pcnt_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      raddr_a_q <= raddr_a_d;
      raddr_b_q <= raddr_b_d;
      dout_a_q  <= dout_a_d;
      dout_b_q  <= dout_b_d;
    end
  end

  assign din_ready  = (state_q == WRITE);
  assign enable_w   = wen_q;
  assign address_w  = waddr_q;
  assign In         = wdata_q;
  assign enable_a   = (state_q == RD_ISSUE);
  assign enable_b   = (state_q == RD_ISSUE);
  assign address_a  = raddr_a_q;
  assign address_b  = raddr_b_q;
  assign dout_a     = dout_a_q;
  assign dout_b     = dout_b_q;
  assign dout_valid = (state_q == RD_OUT);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FIN);

endmodule

// File: tb/tb_regfile_seq.sv
// Bench for regfile_seq: an external register-file model plus a reference
// of which word must appear where, driven by a table of sequence scenarios
// and hand-written reset sequences.
module tb_regfile_seq;

  logic        clk = 1'b0;
  logic        rst, start, din_valid, din_ready, enable_w, enable_a, enable_b;
  logic        dout_valid, dout_ready, busy, done;
  logic [31:0] din, In, OutA, OutB, dout_a, dout_b;
  logic [4:0]  address_w, address_a, address_b;

  regfile_seq #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .address_w(address_w), .enable_w(enable_w), .In(In),
    .address_a(address_a), .address_b(address_b), .enable_a(enable_a),
    .enable_b(enable_b), .OutA(OutA), .OutB(OutB), .dout_a(dout_a),
    .dout_b(dout_b), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // External register file: one write port, two registered read ports.
  logic [31:0] rf [32];
  always @(posedge clk) begin
    if (enable_w) rf[address_w] <= In;
    if (enable_a) OutA <= rf[address_a];
    if (enable_b) OutB <= rf[address_b];
  end

  typedef struct {
    int vmode;      // 0 always valid, 1 toggled, 2 random
    int rmode;      // 0 always ready, 1 stall 5 cycles at pair 3, 2 random
    bit rdata;      // random data words instead of i*0x01010101
    bit noise;      // start pulses in RD_OUT and din_valid during reads
    int exp_writes;
    int exp_pairs;
    int exp_done;
    int exp_stall;  // -1: not checked
  } seq_t;

  int checks = 0;
  int errors = 0;

  logic [31:0] words [32];
  int  acc_cnt, wr_cnt, pair_cnt, done_cnt, stall_cycles, last_issue, mcyc;
  int  cur_rmode;
  bit  mon_en = 1'b0;
  bit  prev_acc, stall_prev;
  logic [31:0] hold_a, hold_b;

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic init_seq(input bit rdata, input int rmode);
    for (int i = 0; i < 32; i++)
      words[i] = rdata ? $urandom : i * 32'h01010101;
    acc_cnt = 0; wr_cnt = 0; pair_cnt = 0; done_cnt = 0;
    stall_cycles = 0; last_issue = -1; prev_acc = 0; stall_prev = 0;
    cur_rmode = rmode;
  endtask

  // Monitor, sampled on the falling edge.
  always @(negedge clk) begin
    mcyc++;
    if (mon_en) begin
      chk(enable_w == prev_acc, "wr_strobe", {31'b0, enable_w}, {31'b0, prev_acc});
      if (enable_w && wr_cnt < 32) begin
        chk(address_w == wr_cnt[4:0], "wr_addr", {27'b0, address_w}, wr_cnt);
        chk(In == words[wr_cnt], "wr_data", In, words[wr_cnt]);
        if (enable_a || enable_b)
          chk(address_w == 5'd31, "wr_rd_overlap", {27'b0, address_w}, 32'd31);
        wr_cnt++;
      end
      if (acc_cnt >= 32) chk(!din_ready, "no_33rd", {31'b0, din_ready}, 32'd0);
      prev_acc = din_valid && din_ready;
      if (prev_acc) acc_cnt++;
      if (enable_a) begin
        chk(address_a == pair_cnt[4:0], "rd_addr_a", {27'b0, address_a}, pair_cnt);
        chk(address_b == pair_cnt[4:0] + 5'd16, "rd_addr_b", {27'b0, address_b}, pair_cnt + 16);
        if (cur_rmode == 0 && last_issue >= 0)
          chk(mcyc - last_issue == 3, "throughput", mcyc - last_issue, 32'd3);
        last_issue = mcyc;
      end
      if (stall_prev) begin
        chk(dout_valid, "stall_valid", {31'b0, dout_valid}, 32'd1);
        chk(dout_a == hold_a, "stall_a", dout_a, hold_a);
        chk(dout_b == hold_b, "stall_b", dout_b, hold_b);
        chk(!enable_a && !enable_b, "stall_rd_en", {31'b0, enable_a}, 32'd0);
      end
      hold_a = dout_a; hold_b = dout_b;
      stall_prev = dout_valid && !dout_ready;
      if (stall_prev) stall_cycles++;
      if (dout_valid && dout_ready && pair_cnt < 16) begin
        chk(dout_a == words[pair_cnt], "dout_a", dout_a, words[pair_cnt]);
        chk(dout_b == words[pair_cnt + 16], "dout_b", dout_b, words[pair_cnt + 16]);
        $display("pair %0d a=%h b=%h", pair_cnt, dout_a, dout_b);
        pair_cnt++;
      end
      if (done) begin
        done_cnt++;
        chk(pair_cnt == 16, "done_pairs", pair_cnt, 32'd16);
      end
    end
  end

  task automatic run_seq(input seq_t v);
    int cyc, stall_left;
    init_seq(v.rdata, v.rmode);
    stall_left = 5;
    mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      @(posedge clk); #1;
      start = v.noise ? dout_valid : 1'b0;
      if (acc_cnt < 32) begin
        case (v.vmode)
          0: din_valid = 1'b1;
          1: din_valid = (cyc % 2 == 0);
          default: din_valid = ($urandom_range(0, 1) == 1);
        endcase
        din = words[acc_cnt];
      end else begin
        din_valid = v.noise;
        din = 32'hDEADBEEF;
      end
      case (v.rmode)
        0: dout_ready = 1'b1;
        1: begin
          if (pair_cnt == 3 && dout_valid && stall_left > 0) begin
            dout_ready = 1'b0;
            stall_left--;
          end else dout_ready = 1'b1;
        end
        default: dout_ready = ($urandom_range(0, 3) != 0);
      endcase
      cyc++;
    end
    chk(done_cnt > 0, "done_timeout", cyc, 32'd3000);
    start = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk(done_cnt == v.exp_done, "done_count", done_cnt, v.exp_done);
    chk(wr_cnt == v.exp_writes, "write_count", wr_cnt, v.exp_writes);
    chk(pair_cnt == v.exp_pairs, "pair_count", pair_cnt, v.exp_pairs);
    chk(!busy, "idle_after", {31'b0, busy}, 32'd0);
    if (v.exp_stall >= 0)
      chk(stall_cycles == v.exp_stall, "stall_cycles", stall_cycles, v.exp_stall);
    mon_en = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({din_ready, enable_w, enable_a, enable_b, dout_valid, busy, done} == 7'b0,
        {tag, "_flags"}, {25'b0, din_ready, enable_w, enable_a, enable_b, dout_valid, busy, done}, 32'd0);
    chk({address_w, address_a, address_b} == 15'b0, {tag, "_addr"},
        {17'b0, address_w, address_a, address_b}, 32'd0);
    chk(In == 32'd0, {tag, "_in"}, In, 32'd0);
    chk(dout_a == 32'd0 && dout_b == 32'd0, {tag, "_dout"}, dout_a | dout_b, 32'd0);
  endtask

  seq_t tbl [5];

  initial begin
    int cyc;
    tbl[0] = '{0, 0, 1'b0, 1'b0, 32, 16, 1, 0};
    tbl[1] = '{1, 0, 1'b1, 1'b0, 32, 16, 1, 0};
    tbl[2] = '{0, 1, 1'b0, 1'b0, 32, 16, 1, 5};
    tbl[3] = '{2, 2, 1'b1, 1'b0, 32, 16, 1, -1};
    tbl[4] = '{0, 0, 1'b1, 1'b1, 32, 16, 1, 0};

    rst = 1'b1; start = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    mcyc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    for (int t = 0; t < 5; t++) begin
      run_seq(tbl[t]);
      $display("sequence %0d vmode=%0d rmode=%0d noise=%0d writes=%0d pairs=%0d done=%0d",
               t, tbl[t].vmode, tbl[t].rmode, tbl[t].noise, wr_cnt, pair_cnt, done_cnt);
    end

    // Reset in the middle of the fill, with the write counter at 10.
    init_seq(1'b0, 0);
    mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; din_valid = 1'b1; din = words[0];
    cyc = 0;
    while (acc_cnt < 10 && cyc < 100) begin
      @(posedge clk); #1;
      din = words[acc_cnt];
      cyc++;
    end
    chk(acc_cnt == 10, "midrst_reach", acc_cnt, 32'd10);
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; din_valid = 1'b0;
    chk_all_zero("midrst");
    $display("mid-write reset applied at wcnt=%0d", acc_cnt);

    // Restart after the abort must begin again at address 0.
    run_seq(tbl[0]);
    $display("restart sequence writes=%0d pairs=%0d done=%0d", wr_cnt, pair_cnt, done_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
